imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Loads a program into the byte-wide little-endian instruction memory of the RV32 datapath before execution.
//  - Accepts 32-bit instruction words over a valid/ready stream and writes each word as 4 byte-writes.
//  - Holds the datapath stalled while loading, then pulses a PC reset and releases it to run.
//  - Sits between the host/testbench program source, the imem write port and the datapath control inputs.
// PARAMETERS
//  ADDR_W   12  imem byte-address width (2**ADDR_W bytes; default 4096)
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       async active-low reset
//  start        in   1       pulse: begin a (re)load at address 0
//  in_valid     in   1       instruction word valid
//  in_ready     out  1       loader can accept a word
//  in_data      in   32      instruction word
//  in_last      in   1       qualifies final word of program
//  im_we        out  1       imem byte write enable
//  im_addr      out  ADDR_W  imem byte address
//  im_wdata     out  8       imem byte data
//  dp_stall     out  1       1 = datapath held (no PC advance, no writes)
//  dp_pc_rst    out  1       1-cycle pulse: datapath PC <= 0
//  done         out  1       program loaded, datapath running
//  err          out  1       imem overflow; sticky until start
//  checksum     out  32      running word sum (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, dp_stall=1; in_ready, im_we, dp_pc_rst, done, err = 0.
//    im_addr=0, checksum=0. A partial word is discarded.
//  - States: IDLE, LOAD, WRITE, RELEASE, RUN, ERROR. All outputs are registered.
//  - IDLE:
//    - start -> LOAD, byte address reset to 0.
//    - in_valid is ignored (in_ready=0), so start together with in_valid produces no handshake.
//  - LOAD:
//    - in_ready=1.
//    - in_valid&in_ready: latch in_data/in_last, in_ready=0 next cycle -> WRITE.
//  - WRITE:
//    - 4 consecutive cycles with im_we=1 at addresses A, A+1, A+2, A+3.
//    - Byte k is in_data[8k+7:8k] (little-endian).
//    - Word accepted at cycle t produces writes at t+1..t+4. im_addr advances by 1 per write.
//  - After byte 3, in priority order:
//    1. last=1 -> RELEASE.
//    2. Address wrapped to 0 (byte 0xFFF just written) -> ERROR.
//    3. Otherwise -> LOAD, with in_ready=1 at t+5.
//    Throughput is 1 word per 5 cycles.
//  - RELEASE: dp_pc_rst=1 for exactly 1 cycle with dp_stall still 1 -> RUN.
//  - RUN: dp_stall=0, done=1. A start pulse -> LOAD next cycle with dp_stall=1, done=0, address 0.
//  - ERROR: err=1, dp_stall=1, in_ready=0. Only start (-> LOAD, err cleared) or reset exits.
//  - start is ignored in LOAD and WRITE.
//  - im_wdata is 0 whenever im_we=0.
// CONFIGURATION
//  Macro IMEM_BOOT_CHECKSUM_EN:
//  - Defined: checksum += in_data (mod 2**32) on each accepted word. Cleared on start and on reset.
//  - Undefined: no accumulator is built and checksum is tied to 0.
// STRUCTURE
//  Package imem_boot_pkg holds:
//  - boot_state_e enum.
//  - BYTES_PER_WORD=4.
//  - IMEM_ADDR_W_DEFAULT=12.
//  No sub-module: a single FSM plus a byte-index counter, both in this file.
// TESTING
//  1. Reset, start, stream 0x00500613 (last=1):
//     - im writes 0x000=13, 0x001=06, 0x002=50, 0x003=00.
//     - dp_pc_rst pulses once, then done=1, dp_stall=0.
//  2. Stream 7 words 0x00500613, 0x00B06693, 0x00C68733, 0x40C787B3, 0x01077813, 0x00D868B3, 0x00D80933 (last on 7th):
//     - 28 byte writes at addresses 0x000..0x01B.
//     - in_ready low 4 cycles after each accept.
//     - Checksum equals the sum of the 7 words when the macro is defined, 0 otherwise.
//  3. in_valid toggling randomly in LOAD:
//     - No word is lost or duplicated; the byte sequence matches test 2.
//  4. ADDR_W=4 (4 words), stream 5 words with no last:
//     - After the 4th word, err=1, in_ready=0, dp_stall=1.
//     - A later start clears err and reloads from 0x0.
//  5. rst_n low during the 2nd byte write of word 1:
//     - Outputs immediately take reset values; no further im_we.
//     - start plus a reload writes the correct bytes from 0x000.
//  6. start during RUN:
//     - dp_stall=1 and done=0 next cycle, in_ready=1.
//     - start asserted during WRITE has no effect.

Source files
------------

// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_RELEASE,
        ST_RUN,
        ST_ERROR
    } boot_state_e;

    localparam int BYTES_PER_WORD      = 4;
    localparam int IMEM_ADDR_W_DEFAULT = 12;

    // Little-endian byte lane k of a 32-bit word.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] k);
        return w[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// Streams 32-bit words into byte-wide imem, then pulses PC reset and releases the datapath (IMEM_BOOT_CHECKSUM_EN adds a word-sum accumulator).
// Latency: word accepted at cycle t is written at t+1..t+4; in_ready returns at t+5 (1 word per 5 cycles).
// Backpressure: in_ready is high only while waiting for a word; it drops for the 4 write cycles and in IDLE/RUN/ERROR.
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [7:0]        im_wdata,
    output logic              dp_stall,
    output logic              dp_pc_rst,
    output logic              done,
    output logic              err,
    output logic [31:0]       checksum
);

    localparam logic [1:0] LAST_BIDX = 2'(BYTES_PER_WORD - 1);

    boot_state_e       state_q, state_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [31:0]       word_q;
    logic              last_q;
    logic              accept, restart, last_byte;

    logic              in_ready_d, im_we_d, dp_stall_d, dp_pc_rst_d, done_d, err_d;
    logic [ADDR_W-1:0] im_addr_d;
    logic [7:0]        im_wdata_d;

    assign accept    = (state_q == ST_LOAD) && in_valid && in_ready;
    assign restart   = start && (state_q inside {ST_IDLE, ST_RUN, ST_ERROR});
    assign last_byte = (state_q == ST_WRITE) && (bidx_q == LAST_BIDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RUN, ST_ERROR: if (restart) state_d = ST_LOAD;
            ST_LOAD:    if (accept) state_d = ST_WRITE;
            // wptr_q already points past byte 3, so zero here means the top byte was just written
            ST_WRITE: begin
                if (last_byte) begin
                    if (last_q)              state_d = ST_RELEASE;
                    else if (wptr_q == '0)   state_d = ST_ERROR;
                    else                     state_d = ST_LOAD;
                end
            end
            ST_RELEASE: state_d = ST_RUN;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        in_ready_d  = (state_d == ST_LOAD);
        im_we_d     = (state_d == ST_WRITE);
        dp_stall_d  = (state_d != ST_RUN);
        dp_pc_rst_d = (state_d == ST_RELEASE);
        done_d      = (state_d == ST_RUN);
        err_d       = (state_d == ST_ERROR);
        bidx_d      = bidx_q;
        wptr_d      = wptr_q;
        im_addr_d   = im_addr;
        im_wdata_d  = '0;
        if (restart) begin
            wptr_d    = '0;
            im_addr_d = '0;
        end
        if (accept) begin
            bidx_d     = '0;
            im_addr_d  = wptr_q;
            wptr_d     = wptr_q + ADDR_W'(1);
            im_wdata_d = word_byte(in_data, 2'd0);
        end else if ((state_q == ST_WRITE) && !last_byte) begin
            bidx_d     = bidx_q + 2'd1;
            im_addr_d  = wptr_q;
            wptr_d     = wptr_q + ADDR_W'(1);
            im_wdata_d = word_byte(word_q, bidx_q + 2'd1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            im_we     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            dp_stall  <= 1'b1;
            dp_pc_rst <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            bidx_q    <= '0;
            wptr_q    <= '0;
            word_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            im_we     <= im_we_d;
            im_addr   <= im_addr_d;
            im_wdata  <= im_wdata_d;
            dp_stall  <= dp_stall_d;
            dp_pc_rst <= dp_pc_rst_d;
            done      <= done_d;
            err       <= err_d;
            bidx_q    <= bidx_d;
            wptr_q    <= wptr_d;
            if (accept) begin
                word_q <= in_data;
                last_q <= in_last;
            end
        end
    end

`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [31:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sum_q <= '0;
        else if (restart) sum_q <= '0;
        else if (accept)  sum_q <= sum_q + in_data;
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: default-size instance plus a 16-byte instance for overflow.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, in_last;
    logic [31:0] in_data;

    logic        in_ready, im_we, dp_stall, dp_pc_rst, done, err;
    logic [11:0] im_addr;
    logic [7:0]  im_wdata;
    logic [31:0] checksum;

    logic        in_ready4, im_we4, dp_stall4, dp_pc_rst4, done4, err4;
    logic [3:0]  im_addr4;
    logic [7:0]  im_wdata4;
    logic [31:0] checksum4;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         q0[$];
    wr_t         q4[$];
    bit          mon0_en = 1'b0;
    bit          mon4_en = 1'b0;
    logic [11:0] exp_a0, exp_a4;

    logic [31:0] prog [7] = '{32'h00500613, 32'h00B06693, 32'h00C68733, 32'h40C787B3,
                              32'h01077813, 32'h00D868B3, 32'h00D80933};

    always #5 clk = ~clk;

    imem_boot_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .dp_stall(dp_stall), .dp_pc_rst(dp_pc_rst), .done(done),
        .err(err), .checksum(checksum)
    );

    imem_boot_loader #(.ADDR_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
        .in_data(in_data), .in_last(in_last), .im_we(im_we4), .im_addr(im_addr4),
        .im_wdata(im_wdata4), .dp_stall(dp_stall4), .dp_pc_rst(dp_pc_rst4), .done(done4),
        .err(err4), .checksum(checksum4)
    );

    // Write monitors: every observed byte write pops one expected entry.
    always @(negedge clk) begin
        wr_t e;
        if (mon0_en) begin
            if (im_we) begin
                checks++;
                if (q0.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write addr=%h data=%h (no write expected)", im_addr, im_wdata);
                end else begin
                    e = q0.pop_front();
                    if (im_addr !== e.addr || im_wdata !== e.data) begin
                        failures++;
                        $display("FAIL write addr=%h data=%h expected addr=%h data=%h", im_addr, im_wdata, e.addr, e.data);
                    end
                end
            end else begin
                checks++;
                if (im_wdata !== 8'h00) begin
                    failures++;
                    $display("FAIL wdata_idle got=%h expected=00", im_wdata);
                end
            end
        end
        if (mon4_en && im_we4) begin
            checks++;
            if (q4.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write4 addr=%h data=%h (no write expected)", im_addr4, im_wdata4);
            end else begin
                e = q4.pop_front();
                if ({8'h00, im_addr4} !== e.addr || im_wdata4 !== e.data) begin
                    failures++;
                    $display("FAIL write4 addr=%h data=%h expected addr=%h data=%h", im_addr4, im_wdata4, e.addr, e.data);
                end
            end
        end
    end

    task automatic push_byte(input bit sel, input logic [11:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        if (sel) q4.push_back(e);
        else     q0.push_back(e);
    endtask

    task automatic push_exp(input bit sel, input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            if (sel) begin
                push_byte(1'b1, exp_a4, w[8*k +: 8]);
                exp_a4 = (exp_a4 + 12'd1) & 12'h00F;
            end else begin
                push_byte(1'b0, exp_a0, w[8*k +: 8]);
                exp_a0 = exp_a0 + 12'd1;
            end
        end
    endtask

    // Returns one cycle after the handshake edge, i.e. during the first write cycle.
    task automatic send_word(input bit sel, input logic [31:0] w, input logic last, input bit rnd);
        bit ok;
        int n;
        in_data = w;
        in_last = last;
        n = 0;
        do begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ok = in_valid && (sel ? in_ready4 : in_ready);
            @(posedge clk); #1;
            n++;
        end while (!ok && n < 200);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout word=%h got=no_handshake expected=handshake", w);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        rst_n = 1'b0;
        q0.delete();
        q4.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_run(input string tag);
        int pulses = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(posedge clk); #1;
            if (dp_pc_rst) begin
                pulses++;
                checks++;
                if (dp_stall !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_stall_in_release got=%b expected=1", tag, dp_stall);
                end
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL %s_pc_rst_pulses got=%0d expected=1", tag, pulses);
        end
        checks++;
        if (done !== 1'b1 || dp_stall !== 1'b0) begin
            failures++;
            $display("FAIL %s_run got done=%b stall=%b expected done=1 stall=0", tag, done, dp_stall);
        end
        checks++;
        if (q0.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_writes got=%0d pending expected=0", tag, q0.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        #12;
        checks++;
        if (in_ready !== 1'b0 || im_we !== 1'b0 || dp_stall !== 1'b1 || dp_pc_rst !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0 || im_addr !== 12'h000 || checksum !== 32'h0) begin
            failures++;
            $display("FAIL reset_values got rdy=%b we=%b stall=%b pcr=%b done=%b err=%b addr=%h sum=%h expected 0,0,1,0,0,0,000,0",
                     in_ready, im_we, dp_stall, dp_pc_rst, done, err, im_addr, checksum);
        end
        do_reset();
    endtask

    task automatic test_single_word();
        do_reset();
        mon0_en = 1'b1;
        mon4_en = 1'b0;
        // start with in_valid already high must not handshake while idle
        in_valid = 1'b1; in_data = 32'hDEADBEEF;
        pulse_start();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_to_load in_ready got=%b expected=1", in_ready);
        end
        push_byte(1'b0, 12'h000, 8'h13);
        push_byte(1'b0, 12'h001, 8'h06);
        push_byte(1'b0, 12'h002, 8'h50);
        push_byte(1'b0, 12'h003, 8'h00);
        send_word(1'b0, 32'h00500613, 1'b1, 1'b0);
        wait_run("single");
    endtask

    task automatic test_stream();
        int gap;
        logic [31:0] sum = '0;
        pulse_start();
        checks++;
        if (done !== 1'b0 || dp_stall !== 1'b1 || checksum !== 32'h0) begin
            failures++;
            $display("FAIL stream_restart got done=%b stall=%b sum=%h expected 0,1,0", done, dp_stall, checksum);
        end
        exp_a0 = 12'h000;
        for (int i = 0; i < 7; i++) begin
            push_exp(1'b0, prog[i]);
            sum = sum + prog[i];
            send_word(1'b0, prog[i], (i == 6), 1'b0);
            if (i < 6) begin
                gap = 0;
                while (in_ready == 1'b0 && gap < 20) begin
                    @(posedge clk); #1;
                    gap++;
                end
                checks++;
                if (gap != 4) begin
                    failures++;
                    $display("FAIL ready_gap word=%0d got=%0d expected=4", i, gap);
                end
            end
        end
        wait_run("stream");
`ifdef IMEM_BOOT_CHECKSUM_EN
        checks++;
        if (checksum !== sum) begin
            failures++;
            $display("FAIL checksum got=%h expected=%h", checksum, sum);
        end
`else
        checks++;
        if (checksum !== 32'h0) begin
            failures++;
            $display("FAIL checksum got=%h expected=00000000", checksum);
        end
`endif
    endtask

    task automatic test_random_valid();
        pulse_start();
        exp_a0 = 12'h000;
        for (int i = 0; i < 7; i++) begin
            push_exp(1'b0, prog[i]);
            send_word(1'b0, prog[i], (i == 6), 1'b1);
        end
        wait_run("random");
    endtask

    task automatic test_overflow();
        int acc = 0;
        do_reset();
        mon0_en = 1'b0;
        mon4_en = 1'b1;
        pulse_start();
        exp_a4 = 12'h000;
        for (int i = 0; i < 4; i++) begin
            push_exp(1'b1, prog[i]);
            send_word(1'b1, prog[i], 1'b0, 1'b0);
        end
        repeat (6) begin @(posedge clk); #1; end
        checks++;
        if (err4 !== 1'b1 || in_ready4 !== 1'b0 || dp_stall4 !== 1'b1 || done4 !== 1'b0) begin
            failures++;
            $display("FAIL overflow_state got err=%b rdy=%b stall=%b done=%b expected 1,0,1,0", err4, in_ready4, dp_stall4, done4);
        end
        in_valid = 1'b1; in_data = prog[4];
        repeat (10) begin
            if (in_ready4) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (acc != 0 || err4 !== 1'b1) begin
            failures++;
            $display("FAIL overflow_hold got accepts=%0d err=%b expected 0,1", acc, err4);
        end
        checks++;
        if (q4.size() != 0) begin
            failures++;
            $display("FAIL overflow_writes got=%0d pending expected=0", q4.size());
        end
        pulse_start();
        checks++;
        if (err4 !== 1'b0 || in_ready4 !== 1'b1) begin
            failures++;
            $display("FAIL overflow_restart got err=%b rdy=%b expected 0,1", err4, in_ready4);
        end
        exp_a4 = 12'h000;
        push_exp(1'b1, prog[4]);
        send_word(1'b1, prog[4], 1'b1, 1'b0);
        for (int i = 0; i < 20 && !done4; i++) begin @(posedge clk); #1; end
        checks++;
        if (done4 !== 1'b1 || q4.size() != 0) begin
            failures++;
            $display("FAIL overflow_reload got done=%b pending=%0d expected 1,0", done4, q4.size());
        end
        mon4_en = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        mon0_en = 1'b1;
        pulse_start();
        push_byte(1'b0, 12'h000, 8'h13);
        send_word(1'b0, 32'h00500613, 1'b0, 1'b0);
        @(posedge clk); #2;
        checks++;
        if (im_we !== 1'b1 || im_addr !== 12'h001) begin
            failures++;
            $display("FAIL second_write got we=%b addr=%h expected 1,001", im_we, im_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (im_we !== 1'b0 || dp_stall !== 1'b1 || in_ready !== 1'b0 || im_addr !== 12'h000 ||
            done !== 1'b0 || err !== 1'b0 || dp_pc_rst !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got we=%b stall=%b rdy=%b addr=%h done=%b err=%b pcr=%b expected 0,1,0,000,0,0,0",
                     im_we, dp_stall, in_ready, im_addr, done, err, dp_pc_rst);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) begin @(posedge clk); #1; end
        checks++;
        if (q0.size() != 0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle got pending=%0d rdy=%b expected 0,0", q0.size(), in_ready);
        end
        pulse_start();
        exp_a0 = 12'h000;
        push_exp(1'b0, prog[0]);
        push_exp(1'b0, prog[1]);
        send_word(1'b0, prog[0], 1'b0, 1'b0);
        send_word(1'b0, prog[1], 1'b1, 1'b0);
        wait_run("reload");
    endtask

    task automatic test_start_in_run();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (dp_stall !== 1'b1 || done !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL start_in_run got stall=%b done=%b rdy=%b expected 1,0,1", dp_stall, done, in_ready);
        end
        exp_a0 = 12'h000;
        push_exp(1'b0, prog[2]);
        send_word(1'b0, prog[2], 1'b0, 1'b0);
        start = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b0;
        push_exp(1'b0, prog[3]);
        send_word(1'b0, prog[3], 1'b1, 1'b0);
        wait_run("start_in_write");
`ifdef IMEM_BOOT_CHECKSUM_EN
        checks++;
        if (checksum !== prog[2] + prog[3]) begin
            failures++;
            $display("FAIL checksum_restart got=%h expected=%h", checksum, prog[2] + prog[3]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stream();
        test_random_valid();
        test_overflow();
        test_reset_mid_write();
        test_start_in_run();
        mon0_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
